// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between the MEM pipeline stage and a req/gnt/rvalid data bus.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   valid_i / ready_o             request handshake from the pipeline (ready only in IDLE)
//   we_i, type_i, sign_ext_i      store/load, access size (byte/half/word/dword), sign extension
//   addr_i, wdata_i               byte address, LSB-aligned store data
//   valid_o, rdata_o, err_o       one-cycle completion pulse, extended load data, error flag
//   data_req_o / data_gnt_i / data_rvalid_i   bus handshake
//   data_addr_o, data_we_o, data_be_o, data_wdata_o, data_rdata_i   bus address/control/data
//
// Build option: define MISALIGN_TRAP_EN to report misaligned accesses as errors without a
// bus request. Otherwise the address is aligned down to the access size and performed normally.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    we_i,
  input  logic [1:0]              type_i,
  input  logic                    sign_ext_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  input  logic                    data_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned OffW = $clog2(BeW);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRvalid} state_e;

  state_e          state_q;
  logic [1:0]      type_q;
  logic            sign_q;
  logic            we_q;
  logic [OffW-1:0] off_q;

  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] addr_use;
  logic                  acc_err;
  logic [OffW-1:0]       off;
  logic [BeW-1:0]        size_be;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld_res;
  logic                  sbit;
  int                    nbits;

  // Request decode: size mask, error detection and effective address.
  always_comb begin
    unique case (type_i)
      2'b00:   begin size_be = BeW'(1);     size_mask = ADDR_WIDTH'(0); end
      2'b01:   begin size_be = BeW'(3);     size_mask = ADDR_WIDTH'(1); end
      2'b10:   begin size_be = BeW'(15);    size_mask = ADDR_WIDTH'(3); end
      default: begin size_be = BeW'(8'hFF); size_mask = ADDR_WIDTH'(7); end
    endcase
    acc_err = (DATA_WIDTH == 32) && (type_i == 2'b11);
`ifdef MISALIGN_TRAP_EN
    addr_use = addr_i;
    acc_err  = acc_err || ((addr_i & size_mask) != '0);
`else
    addr_use = addr_i & ~size_mask;
`endif
    off = addr_use[OffW-1:0];
  end

  // Load extraction: shift the addressed lane down, then extend above the access size.
  always_comb begin
    shifted = data_rdata_i >> {off_q, 3'b000};
    unique case (type_q)
      2'b00:   begin sbit = shifted[7];            nbits = 8;          end
      2'b01:   begin sbit = shifted[15];           nbits = 16;         end
      2'b10:   begin sbit = shifted[31];           nbits = 32;         end
      default: begin sbit = shifted[DATA_WIDTH-1]; nbits = DATA_WIDTH; end
    endcase
    ld_res = shifted;
    for (int i = 8; i < DATA_WIDTH; i++) begin
      if (i >= nbits) ld_res[i] = sign_q & sbit;
    end
  end

  assign ready_o = (state_q == StIdle);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      type_q       <= 2'b00;
      sign_q       <= 1'b0;
      we_q         <= 1'b0;
      off_q        <= '0;
      valid_o      <= 1'b0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else begin
      valid_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (acc_err) begin
              // Completes next cycle without touching the bus; stay ready.
              valid_o <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= '0;
            end else begin
              type_q       <= type_i;
              sign_q       <= sign_ext_i;
              we_q         <= we_i;
              off_q        <= off;
              data_req_o   <= 1'b1;
              data_we_o    <= we_i;
              data_be_o    <= size_be << off;
              data_addr_o  <= addr_use & ~ADDR_WIDTH'(BeW - 1);
              data_wdata_o <= wdata_i << {off, 3'b000};
              state_q      <= StReq;
            end
          end
        end
        StReq: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_q    <= StWaitRvalid;
          end
        end
        StWaitRvalid: begin
          if (data_rvalid_i) begin
            valid_o <= 1'b1;
            err_o   <= 1'b0;
            rdata_o <= we_q ? '0 : ld_res;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i, we_i, sign_ext_i;
  logic [1:0]  type_i;
  logic [31:0] addr_i, wdata_i;
  logic        ready_o, valid_o, err_o;
  logic [31:0] rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .we_i         (we_i),
    .type_i       (type_i),
    .sign_ext_i   (sign_ext_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .valid_o      (valid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .data_req_o   (data_req_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_rdata_i (data_rdata_i)
  );

  // Scoreboard: every completion pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_completion: rdata_o=%h err_o=%b, none expected", rdata_o, err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rdata_o, err_o} !== {e.rdata, e.err}) begin
          fails++;
          $display("FAIL completion: got rdata=%h err=%b, expected rdata=%h err=%b",
                   rdata_o, err_o, e.rdata, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] load_model(input logic [31:0] bus, input logic [1:0] ty,
                                             input logic sx, input int off);
    logic [7:0]  b[4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = bus[8*i +: 8];
    case (ty)
      2'd0: begin
        r = {24'h0, b[off]};
        if (sx && b[off][7]) r[31:8] = 24'hFFFFFF;
      end
      2'd1: begin
        r = {16'h0, b[off+1], b[off]};
        if (sx && b[off+1][7]) r[31:16] = 16'hFFFF;
      end
      default: r = bus;
    endcase
    return r;
  endfunction

  // Drive one request; called just after a rising edge, returns just after the accept edge.
  task automatic send(input logic we, input logic [1:0] ty, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; we_i = we; type_i = ty; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Grant after 'dly' cycles, then rvalid the following cycle; returns in the valid_o cycle.
  task automatic respond(input int dly, input logic [31:0] rd);
    repeat (dly) begin @(posedge clk); #1; end
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rd;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
  endtask

  task automatic test_reset;
    valid_i = 0; we_i = 0; type_i = 0; sign_ext_i = 0; addr_i = 0; wdata_i = 0;
    data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ready_o, valid_o, err_o, data_req_o, data_we_o} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 10000",
               {ready_o, valid_o, err_o, data_req_o, data_we_o});
    end
    tests++;
    if ({rdata_o, data_addr_o, data_wdata_o, data_be_o} !== 100'h0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b, expected all zero",
               rdata_o, data_addr_o, data_wdata_o, data_be_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_word_load;
    @(posedge clk); #1;
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    exp_q.push_back('{rdata: 32'h8000_00F0, err: 1'b0});
    @(negedge clk);
    tests++;
    if ({data_req_o, data_we_o, ready_o, data_addr_o, data_be_o} !== {3'b100, 32'h100, 4'hF}) begin
      fails++;
      $display("FAIL word_load_bus: req/we/ready=%b addr=%h be=%b, expected 100 00000100 1111",
               {data_req_o, data_we_o, ready_o}, data_addr_o, data_be_o);
    end
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h8000_00F0;
    @(negedge clk);
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL word_load_early: valid_o=%b at cycle 2, expected 0", valid_o);
    end
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    @(negedge clk);
    tests++;
    if (valid_o !== 1'b1) begin
      fails++;
      $display("FAIL word_load_latency: valid_o=%b at cycle 3, expected 1", valid_o);
    end
  endtask

  task automatic test_byte_load;
    logic [31:0] exp_v;
    for (int sx = 1; sx >= 0; sx--) begin
      exp_v = (sx == 1) ? 32'hFFFF_FF80 : 32'h0000_0080;
      @(posedge clk); #1;
      send(1'b0, 2'b00, sx[0], 32'h103, 32'h0);
      exp_q.push_back('{rdata: exp_v, err: 1'b0});
      @(negedge clk);
      tests++;
      if ({data_addr_o, data_be_o} !== {32'h100, 4'b1000}) begin
        fails++;
        $display("FAIL byte_load_be: addr=%h be=%b, expected 00000100 1000",
                 data_addr_o, data_be_o);
      end
      respond(0, 32'h8000_0000);
      @(negedge clk);
      @(negedge clk);
      tests++;
      if ({valid_o, rdata_o} !== {1'b0, exp_v}) begin
        fails++;
        $display("FAIL byte_load_hold: valid=%b rdata=%h, expected 0 %h", valid_o, rdata_o, exp_v);
      end
    end
  endtask

  task automatic test_half_store;
    @(posedge clk); #1;
    send(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({data_req_o, data_we_o, ready_o, data_addr_o, data_be_o, data_wdata_o} !==
          {3'b110, 32'h100, 4'b1100, 32'hABCD_0000}) begin
        fails++;
        $display("FAIL half_store_stable[%0d]: req/we/ready=%b addr=%h be=%b wdata=%h, expected 110 00000100 1100 abcd0000",
                 i, {data_req_o, data_we_o, ready_o}, data_addr_o, data_be_o, data_wdata_o);
      end
      if (i == 4) data_gnt_i = 1'b1;
    end
    @(posedge clk); #1;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
  endtask

  task automatic test_misalign;
    @(posedge clk); #1;
    send(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    tests++;
    if ({data_req_o, valid_o, err_o} !== 3'b011) begin
      fails++;
      $display("FAIL misalign_trap: req/valid/err=%b, expected 011", {data_req_o, valid_o, err_o});
    end
`else
    exp_q.push_back('{rdata: 32'h1234_5678, err: 1'b0});
    @(negedge clk);
    tests++;
    if ({data_req_o, data_addr_o, data_be_o} !== {1'b1, 32'h100, 4'hF}) begin
      fails++;
      $display("FAIL misalign_align: req=%b addr=%h be=%b, expected 1 00000100 1111",
               data_req_o, data_addr_o, data_be_o);
    end
    respond(0, 32'h1234_5678);
`endif
  endtask

  task automatic test_dword_err;
    @(posedge clk); #1;
    send(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    exp_q.push_back('{rdata: 32'hDEAD_BEEF, err: 1'b0});
    respond(1, 32'hDEAD_BEEF);
    send(1'b0, 2'b11, 1'b1, 32'h200, 32'h0);
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    tests++;
    if ({data_req_o, valid_o, err_o, ready_o, rdata_o} !== {4'b0111, 32'h0}) begin
      fails++;
      $display("FAIL dword_err: req/valid/err/ready=%b rdata=%h, expected 0111 00000000",
               {data_req_o, valid_o, err_o, ready_o}, rdata_o);
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    send(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    data_gnt_i = 1'b1;
    @(posedge clk); #1;
    data_gnt_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({ready_o, data_req_o} !== 2'b10) begin
      fails++;
      $display("FAIL reset_mid_abandon: ready/req=%b, expected 10", {ready_o, data_req_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    data_rvalid_i = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({valid_o, ready_o} !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid_late_rvalid: valid/ready=%b, expected 01", {valid_o, ready_o});
    end
    @(posedge clk); #1;
    send(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    exp_q.push_back('{rdata: 32'h0000_00AB, err: 1'b0});
    respond(0, 32'h0000_AB00);
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ty;
    logic        we, sx;
    int          off;
    logic [31:0] a, wd, rd, exp_v;
    logic [3:0]  exp_be;
    @(posedge clk); #1;
    for (int n = 0; n < 24; n++) begin
      ty = 2'($urandom_range(0, 2));
      we = 1'($urandom_range(0, 1));
      sx = 1'($urandom_range(0, 1));
      off = (ty == 2'd0) ? $urandom_range(0, 3) : (ty == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
      a  = 32'h1000 + ($urandom_range(0, 63) << 2) + off;
      wd = $urandom;
      rd = $urandom;
      exp_be = (ty == 2'd0) ? (4'b0001 << off) : (ty == 2'd1) ? (4'b0011 << off) : 4'b1111;
      exp_v  = we ? 32'h0 : load_model(rd, ty, sx, off);
      send(we, ty, sx, a, wd);
      exp_q.push_back('{rdata: exp_v, err: 1'b0});
      #1;
      tests++;
      if ({data_addr_o, data_be_o, data_wdata_o, data_we_o} !==
          {a & 32'hFFFF_FFFC, exp_be, wd << (8 * off), we}) begin
        fails++;
        $display("FAIL b2b_bus[%0d]: addr=%h be=%b wdata=%h we=%b, expected %h %b %h %b", n,
                 data_addr_o, data_be_o, data_wdata_o, data_we_o,
                 a & 32'hFFFF_FFFC, exp_be, wd << (8 * off), we);
      end
      respond($urandom_range(0, 2), rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_dword_err();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d completions outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width; SHALL be 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32, address width.
REQ-003 clk_i  in  1  clock; single clock domain, rising edge.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 valid_i  in  1  request from MEM pipeline.
REQ-006 ready_o  out  1  unit can accept a request.
REQ-007 we_i  in  1  1 = store, 0 = load.
REQ-008 type_i  in  2  size: 00 byte, 01 half, 10 word, 11 dword.
REQ-009 sign_ext_i  in  1  sign-extend load result.
REQ-010 addr_i  in  ADDR_WIDTH  byte address.
REQ-011 wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
REQ-012 valid_o  out  1  one-cycle completion pulse.
REQ-013 rdata_o  out  DATA_WIDTH  extended load data.
REQ-014 err_o  out  1  completion is an error; qualified by valid_o.
REQ-015 data_req_o / data_gnt_i / data_rvalid_i  out/in/in  1 each  memory handshake.
REQ-016 data_addr_o  out  ADDR_WIDTH  bus address, aligned to DATA_WIDTH/8 bytes.
REQ-017 data_we_o  out  1  bus write enable.
REQ-018 data_be_o  out  DATA_WIDTH/8  byte enables.
REQ-019 data_wdata_o / data_rdata_i  out/in  DATA_WIDTH  bus write/read data.

Function
REQ-020 FSM states IDLE, REQ, WAIT_RVALID; ready_o SHALL be 1 only in IDLE.
REQ-021 IDLE: valid_i & ready_o SHALL latch we, type, sign_ext, addr and wdata, then move to REQ.
REQ-022 REQ: data_req_o SHALL be 1 with all bus outputs stable until the data_gnt_i cycle, then move to WAIT_RVALID.
REQ-023 WAIT_RVALID: on data_rvalid_i, latch the result, go to IDLE; valid_o SHALL pulse the next cycle. Minimum latency from accept to valid_o is 3 cycles. Loads and stores both wait for rvalid.
REQ-024 data_rvalid_i in IDLE or REQ, and data_gnt_i outside REQ, SHALL be ignored.
REQ-025 Lane offset = addr mod (DATA_WIDTH/8). data_be_o = size mask << offset; data_wdata_o = wdata << (8*offset).
REQ-026 Load result = data_rdata_i >> (8*offset), truncated to the access size, then sign- or zero-extended to DATA_WIDTH.
REQ-027 type_i=11 with DATA_WIDTH=32 SHALL complete with err_o=1, no bus request, and rdata_o=0, one cycle after accept.
REQ-028 Misaligned access means half with addr[0]≠0, word with addr[1:0]≠0, or dword with addr[2:0]≠0. Its handling is defined by REQ-033/034.
REQ-029 rdata_o SHALL hold its value between completions. It SHALL be 0 after a store or an error completion.

Reset
REQ-030 Asynchronous reset SHALL force: state IDLE, ready_o=1, valid_o=0, err_o=0, rdata_o=0, data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction. A late rvalid after reset SHALL be ignored per REQ-024.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN selects misalignment handling.
REQ-033 Defined: a misaligned access SHALL issue no bus request. It SHALL complete one cycle after accept with valid_o=1, err_o=1 and rdata_o=0.
REQ-034 Undefined: the address SHALL be aligned down to the access size and the access performed normally. err_o SHALL be 1 only for REQ-027.

Verification
REQ-035 Word load at addr 0x100; gnt in the same cycle as req; rdata_i=0x8000_00F0 -> valid_o 3 cycles after accept, rdata_o=0x8000_00F0, err_o=0.
REQ-036 Byte load, sign_ext=1, addr 0x103, rdata_i=0x8000_0000 -> be=1000, rdata_o=0xFFFF_FF80. Same with sign_ext=0 -> 0x0000_0080.
REQ-037 Half store, wdata 0xABCD, addr 0x102; gnt held low 4 cycles -> req, addr, be=1100 and wdata=0xABCD_0000 stable 5 cycles; ready_o=0 throughout.
REQ-038 Word load at addr 0x101 -> with MISALIGN_TRAP_EN: no data_req_o, err_o=1 one cycle after accept. Without: bus address 0x100, err_o=0.
REQ-039 rst_ni low while in WAIT_RVALID, then rvalid asserted after reset release -> no valid_o, ready_o=1, next request served normally.
